// File: rtl/max_stream_if.sv
// max_stream_if: sample stream in, result stream out, for max_stream.
//   in_valid/in_ready/in_data/in_last : operand stream, in_last closes a group early
//   out_valid/out_ready               : result handshake
//   out_max/out_idx/out_len           : winning value, its index, group length
// slave  = the max_stream block's view, master = the producer/consumer view.
interface max_stream_if #(
  parameter int WIDTH = 8,
  parameter int LEN   = 4
);
  localparam int IW = ($clog2(LEN) > 1) ? $clog2(LEN) : 1;
  localparam int CW = $clog2(LEN + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic [IW-1:0]    out_idx;
  logic [CW-1:0]    out_len;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_max, out_idx, out_len
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_max, out_idx, out_len
  );
endinterface

// File: rtl/max_stream.sv
// max_stream: streaming maximum finder.
// Consumes WIDTH-bit operands in groups of up to LEN samples (a group closes on
// in_last or on the LEN-th sample) and emits one registered result per group:
// full-precision maximum, its 0-based index and the group length.
// The comparator looks only at in_data[WIDTH-1:APPROX_LSB]; SIGNED selects a
// two's-complement compare of that key. Ties keep the earlier sample.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : max_stream_if.slave (sample stream in, result stream out)
module max_stream #(
  parameter int WIDTH      = 8,
  parameter int LEN        = 4,
  parameter bit SIGNED     = 1'b0,
  parameter int APPROX_LSB = 0
) (
  input  logic         clk,
  input  logic         rst,
  max_stream_if.slave  bus
);
  localparam int IW = ($clog2(LEN) > 1) ? $clog2(LEN) : 1;
  localparam int CW = $clog2(LEN + 1);
  localparam int KW = WIDTH - APPROX_LSB;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           r_state;
  logic [IW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc_max;
  logic [IW-1:0]    r_acc_idx;
  logic [WIDTH-1:0] r_out_max;
  logic [IW-1:0]    r_out_idx;
  logic [CW-1:0]    r_out_len;

  logic             w_ending;
  logic             w_in_ready;
  logic             w_xfer;
  logic             w_close;
  logic [KW-1:0]    w_new_key;
  logic [KW-1:0]    w_acc_key;
  logic             w_new_wins;
  logic [WIDTH-1:0] w_win_max;
  logic [IW-1:0]    w_win_idx;

  // The current sample closes the group if flagged last or if it is the LEN-th.
  assign w_ending   = bus.in_last | (r_cnt == IW'(LEN - 1));
  // Only a group-closing sample needs the output register; it stalls solely
  // while a result is held and not being drained.
  assign w_in_ready = (r_state == EMPTY) | bus.out_ready | ~w_ending;
  assign w_xfer     = bus.in_valid & w_in_ready;
  assign w_close    = w_xfer & w_ending;

  // Keys drop APPROX_LSB low bits. For a signed compare the key's sign bit is
  // inverted so a plain unsigned magnitude compare orders two's-complement keys.
  always_comb begin
    w_new_key = bus.in_data[WIDTH-1:APPROX_LSB];
    w_acc_key = r_acc_max[WIDTH-1:APPROX_LSB];
    if (SIGNED) begin
      w_new_key[KW-1] = ~w_new_key[KW-1];
      w_acc_key[KW-1] = ~w_acc_key[KW-1];
    end
  end

  // Strictly greater keeps the earlier index on ties; the first sample of a
  // group wins unconditionally so stale accumulator contents never matter.
  assign w_new_wins = (r_cnt == '0) | (w_new_key > w_acc_key);
  assign w_win_max  = w_new_wins ? bus.in_data : r_acc_max;
  assign w_win_idx  = w_new_wins ? r_cnt : r_acc_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= EMPTY;
      r_cnt     <= '0;
      r_acc_max <= '0;
      r_acc_idx <= '0;
      r_out_max <= '0;
      r_out_idx <= '0;
      r_out_len <= '0;
    end else begin
      if (w_xfer) begin
        if (w_ending) begin
          r_cnt <= '0;
        end else begin
          r_cnt     <= r_cnt + IW'(1);
          r_acc_max <= w_win_max;
          r_acc_idx <= w_win_idx;
        end
      end

      if (w_close) begin
        r_out_max <= w_win_max;
        r_out_idx <= w_win_idx;
        r_out_len <= CW'(r_cnt) + CW'(1);
      end

      case (r_state)
        EMPTY: begin
          if (w_close) r_state <= FULL;
        end
        FULL: begin
          // A drain and a new group end in the same cycle reload without a bubble.
          if (bus.out_ready && !w_close) r_state <= EMPTY;
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == FULL);
  assign bus.out_max   = r_out_max;
  assign bus.out_idx   = r_out_idx;
  assign bus.out_len   = r_out_len;

  a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
    r_cnt <= IW'(LEN - 1));

  a_idx_bound: assert property (@(posedge clk) disable iff (rst)
    r_out_idx <= IW'(LEN - 1));

  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable(r_out_max) && $stable(r_out_idx) && $stable(r_out_len)));
endmodule

// File: tb/tb_max_stream.sv
// tb_max_stream: drives the same sample stream into three max_stream instances
// (unsigned exact, signed exact, unsigned with 2 ignored LSBs) and checks them
// against a group-level model plus hand-computed results.
module tb_max_stream;
  localparam int W = 8;
  localparam int L = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tb_in_valid = 1'b0;
  logic       tb_in_last  = 1'b0;
  logic [7:0] tb_in_data  = '0;
  logic       tb_out_ready = 1'b1;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  max_stream_if #(.WIDTH(W), .LEN(L)) bus0 ();
  max_stream_if #(.WIDTH(W), .LEN(L)) bus1 ();
  max_stream_if #(.WIDTH(W), .LEN(L)) bus2 ();

  assign bus0.in_valid = tb_in_valid;  assign bus0.in_data = tb_in_data;
  assign bus0.in_last  = tb_in_last;   assign bus0.out_ready = tb_out_ready;
  assign bus1.in_valid = tb_in_valid;  assign bus1.in_data = tb_in_data;
  assign bus1.in_last  = tb_in_last;   assign bus1.out_ready = tb_out_ready;
  assign bus2.in_valid = tb_in_valid;  assign bus2.in_data = tb_in_data;
  assign bus2.in_last  = tb_in_last;   assign bus2.out_ready = tb_out_ready;

  max_stream #(.WIDTH(W), .LEN(L), .SIGNED(1'b0), .APPROX_LSB(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  max_stream #(.WIDTH(W), .LEN(L), .SIGNED(1'b1), .APPROX_LSB(0)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  max_stream #(.WIDTH(W), .LEN(L), .SIGNED(1'b0), .APPROX_LSB(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endfunction

  // ---------------- group-level model ----------------
  typedef struct packed {
    logic [2:0][7:0] mx;
    logic [2:0][1:0] idx;
    logic [2:0]      len;
  } res_t;

  res_t       q[$];    // results produced but not yet taken downstream
  logic [7:0] grp[$];  // samples of the open group

  function automatic int keyof(logic [7:0] v, int cfg);
    int x;
    x = (cfg == 1) ? int'($signed(v)) : int'(v);
    return (cfg == 2) ? (x >>> 2) : x;
  endfunction

  function automatic res_t model_result();
    res_t r;
    int   best;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      best = 0;
      for (int i = 1; i < grp.size(); i++)
        if (keyof(grp[i], c) > keyof(grp[best], c)) best = i;
      r.mx[c]  = grp[best];
      r.idx[c] = 2'(best);
    end
    r.len = 3'(grp.size());
    return r;
  endfunction

  function automatic void cmp_out(int c, logic [7:0] mx, logic [1:0] idx, logic [2:0] len, res_t e);
    chk($sformatf("mon_max%0d", c), int'(mx), int'(e.mx[c]));
    chk($sformatf("mon_idx%0d", c), int'(idx), int'(e.idx[c]));
    chk($sformatf("mon_len%0d", c), int'(len), int'(e.len));
  endfunction

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        grp.delete();
      end else begin
        bit ending;
        bit exp_rdy;
        bit exp_vld;
        ending  = tb_in_last || (grp.size() == L - 1);
        exp_vld = (q.size() != 0);
        exp_rdy = !(exp_vld && !tb_out_ready && ending);
        chk("mon_in_ready0", int'(bus0.in_ready), int'(exp_rdy));
        chk("mon_in_ready1", int'(bus1.in_ready), int'(exp_rdy));
        chk("mon_in_ready2", int'(bus2.in_ready), int'(exp_rdy));
        chk("mon_out_valid0", int'(bus0.out_valid), int'(exp_vld));
        chk("mon_out_valid1", int'(bus1.out_valid), int'(exp_vld));
        chk("mon_out_valid2", int'(bus2.out_valid), int'(exp_vld));
        if (exp_vld) begin
          cmp_out(0, bus0.out_max, bus0.out_idx, bus0.out_len, q[0]);
          cmp_out(1, bus1.out_max, bus1.out_idx, bus1.out_len, q[0]);
          cmp_out(2, bus2.out_max, bus2.out_idx, bus2.out_len, q[0]);
          if (tb_out_ready) void'(q.pop_front());
        end
        if (tb_in_valid && exp_rdy) begin
          grp.push_back(tb_in_data);
          if (ending) begin
            q.push_back(model_result());
            grp.delete();
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic send(input logic [7:0] d, input logic last);
    int unsigned waits;
    waits = 0;
    tb_in_valid = 1'b1;
    tb_in_data  = d;
    tb_in_last  = last;
    @(negedge clk);
    while (!bus0.in_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!bus0.in_ready) begin
      total++;
      $display("FAIL send_timeout: in_ready got 0, required 1 for data %0d", d);
    end
    @(posedge clk);
    #1;
    tb_in_valid = 1'b0;
    tb_in_last  = 1'b0;
    tb_in_data  = 8'($urandom);
  endtask

  task automatic expect_res(string nm, int m0, int i0, int m1, int i1, int m2, int i2, int len);
    chk({nm, "_valid"}, int'(bus0.out_valid), 1);
    chk({nm, "_max0"}, int'(bus0.out_max), m0);
    chk({nm, "_idx0"}, int'(bus0.out_idx), i0);
    chk({nm, "_len0"}, int'(bus0.out_len), len);
    chk({nm, "_max1"}, int'(bus1.out_max), m1);
    chk({nm, "_idx1"}, int'(bus1.out_idx), i1);
    chk({nm, "_max2"}, int'(bus2.out_max), m2);
    chk({nm, "_idx2"}, int'(bus2.out_idx), i2);
  endtask

  initial begin : stim
    int t0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", int'(bus0.out_valid), 0);
    chk("rst_out_max",   int'(bus0.out_max), 0);
    chk("rst_out_idx",   int'(bus0.out_idx), 0);
    chk("rst_out_len",   int'(bus0.out_len), 0);
    chk("rst_in_ready",  int'(bus0.in_ready), 1);

    // Tie keeps earlier index.
    send(8'd3, 1'b0); send(8'd9, 1'b0); send(8'd9, 1'b0); send(8'd1, 1'b0);
    expect_res("tie", 9, 1, 9, 1, 9, 1, 4);

    // Signed vs unsigned ordering.
    send(8'h80, 1'b0); send(8'hFF, 1'b0); send(8'h05, 1'b0); send(8'h7F, 1'b0);
    expect_res("sign", 'hFF, 1, 'h7F, 3, 'hFF, 1, 4);

    // Early close followed immediately by a full group, no lost cycles.
    t0 = cyc;
    send(8'd4, 1'b0); send(8'd2, 1'b1);
    expect_res("early", 4, 0, 4, 0, 4, 0, 2);
    send(8'd10, 1'b0); send(8'd20, 1'b0); send(8'd30, 1'b0); send(8'd40, 1'b0);
    expect_res("after_early", 40, 3, 40, 3, 40, 3, 4);
    chk("early_cycles", cyc - t0, 6);

    // Approximate compare: equal keys keep the earlier sample.
    send(8'h10, 1'b0); send(8'h13, 1'b0); send(8'h12, 1'b0); send(8'h0F, 1'b0);
    expect_res("approx", 'h13, 1, 'h13, 1, 'h10, 0, 4);

    // Backpressure.
    send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
    expect_res("bp_first", 4, 3, 4, 3, 4, 3, 4);
    tb_out_ready = 1'b0;
    t0 = cyc;
    send(8'd7, 1'b0); send(8'd9, 1'b0); send(8'd2, 1'b0);
    chk("bp_accept_cycles", cyc - t0, 3);
    tb_in_valid = 1'b1; tb_in_data = 8'd5; tb_in_last = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_stall_ready", int'(bus0.in_ready), 0);
      chk("bp_hold_max", int'(bus0.out_max), 4);
      chk("bp_hold_idx", int'(bus0.out_idx), 3);
    end
    @(posedge clk); #1;
    tb_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", int'(bus0.in_ready), 1);
    @(posedge clk); #1;
    tb_in_valid = 1'b0;
    expect_res("bp_second", 9, 1, 9, 1, 9, 1, 4);

    // Reset with an undelivered result and a partial group.
    tb_out_ready = 1'b0;
    send(8'd50, 1'b0); send(8'd60, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", int'(bus0.out_valid), 0);
    chk("mid_rst_max",   int'(bus0.out_max), 0);
    chk("mid_rst_idx",   int'(bus0.out_idx), 0);
    chk("mid_rst_len",   int'(bus0.out_len), 0);
    rst = 1'b0;
    tb_out_ready = 1'b1;
    send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
    expect_res("post_rst", 4, 3, 4, 3, 4, 3, 4);

    // Back-to-back single-sample groups.
    t0 = cyc;
    send(8'd5, 1'b1);
    expect_res("one_a", 5, 0, 5, 0, 5, 0, 1);
    send(8'h90, 1'b1);
    expect_res("one_b", 'h90, 0, 'h90, 0, 'h90, 0, 1);
    send(8'd6, 1'b1);
    expect_res("one_c", 6, 0, 6, 0, 6, 0, 1);
    chk("one_cycles", cyc - t0, 3);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin : watchdog
    repeat (5000) @(posedge clk);
    total++;
    $display("FAIL watchdog: run exceeded 5000 cycles");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/max_stream.md
# max_stream

Streaming maximum finder. It consumes a valid/ready stream of WIDTH-bit operands in groups of up to LEN samples and emits one result per group: the maximum value, its index within the group and the group length. It is the sequential, parametrised successor to the combinational max partitions in the approximate-max datapath. APPROX_LSB lets the comparator ignore low-order bits, so accuracy can be traded for comparator size.

## Interface
- WIDTH, 8, operand width in bits (≥2)
- LEN, 4, maximum samples per group (≥2)
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned
- APPROX_LSB, 0, number of low bits ignored by the comparator (0..WIDTH-1)
- Derived: IW = max(1, clog2(LEN)); CW = clog2(LEN+1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  WIDTH  operand
- in_last  in  1  sample closes the group early
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_max  out  WIDTH  full-precision value of the winning sample
- out_idx  out  IW  index of the winner within the group (0-based)
- out_len  out  CW  number of samples in the group (1..LEN)

## Operation
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- Internal accumulator holds acc_max, acc_idx and cnt (samples taken so far in the group).
- Compare key: in_data[WIDTH-1:APPROX_LSB].
  - When SIGNED=1, the key's MSB is the sign bit.
  - The new sample wins only if its key is strictly greater than the acc_max key. Ties keep the earlier index.
  - The first sample of a group (cnt==0) always wins.
- A group ends on an input transfer with in_last=1 or with cnt==LEN-1. On that transfer:
  - The output register loads the winner of {accumulator, current sample}, out_idx, and out_len = cnt+1.
  - cnt clears to 0, so the next transfer starts a new group.
- A group-ending sample that is not the LEN-th sample sets out_len below LEN. in_last on the first sample gives out_len=1 and out_idx=0.
- States:
  - EMPTY (out_valid=0): goes to FULL on a group-ending transfer.
  - FULL (out_valid=1), out_ready=1, group-ending transfer in the same cycle: stays FULL, output reloads with the new result.
  - FULL, out_ready=1, no group-ending transfer: goes to EMPTY.
  - FULL, out_ready=0: holds, and the output fields stay stable.
- in_ready = ~out_valid | out_ready | ~ending, where ending = in_last | (cnt==LEN-1).
  - Non-ending samples are always accepted.
  - An ending sample stalls only while the output is full and not being drained.
  - in_ready must not depend combinationally on in_valid.
- Output fields are stable while out_valid & ~out_ready.
- in_data is ignored when in_valid=0. in_last is ignored without a transfer.

## Timing
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_max=0, out_idx=0, out_len=0.
  - cnt=0, acc_max=0, acc_idx=0.
  - in_ready=1 in the cycle after reset.
  - Reset mid-group discards the partial group and any undelivered result.
- Latency: out_valid rises the cycle after the group-ending transfer (1 cycle).
- Throughput: one sample per cycle sustained, including back-to-back groups of length 1, provided out_ready=1.
- Output is registered; in_ready is combinational from out_valid, out_ready and cnt/in_last.
- Simultaneous output drain and group end: the new result is visible the next cycle with out_valid held high and no bubble.
- cnt never exceeds LEN-1; out_idx never exceeds LEN-1.

## Test plan
- Unsigned, LEN=4, APPROX_LSB=0, out_ready=1: samples 3,9,9,1 -> one cycle after the 4th transfer, out_max=9, out_idx=1, out_len=4 (tie keeps the earlier index).
- SIGNED=1, WIDTH=8: samples 0x80,0xFF,0x05,0x7F -> out_max=0x7F, out_idx=3. Same samples with SIGNED=0 -> out_max=0xFF, out_idx=1.
- Early close with in_last on the 2nd sample (values 4,2), followed immediately by a group of 10,20,30,40 -> results {4,0,2} then {40,3,4}, with no lost cycles.
- APPROX_LSB=2: samples 0x10,0x13,0x12,0x0F -> 0x13 does not beat 0x10 (equal keys), so out_max=0x10, out_idx=0.
- Backpressure: hold out_ready=0 after the first result while a second group streams in. Required response:
  - The first three samples of the second group are accepted.
  - in_ready drops on the 4th sample.
  - out_* stay stable.
  - Raising out_ready drains the first result and accepts the 4th sample in the same cycle; the second result appears next cycle.
- Reset after 2 samples of a group: assert rst, then send 1,2,3,4 -> out_max=4, out_idx=3, out_len=4. No stale result appears, and out_* read 0 while reset is applied.
